ddr4_app_requester: RTL



---
 rtl/ddr4_app_requester.sv | 97 +++++++++
 1 files changed

// File: rtl/ddr4_app_requester.sv
// ddr4_app_requester: in-order request/response initiator for the DDR4 app bridge, with read credits and a response FIFO.
module ddr4_app_requester #(
  parameter int DDR4_APP_ADDR_WIDTH = 28,
  parameter int DDR4_APP_CMD_WIDTH  = 3,
  parameter int DDR4_APP_DATA_WIDTH = 64,
  parameter int TAG_WIDTH           = 4,
  parameter int MAX_OUTSTANDING     = 8
) (
  input  logic                             mem_clk_i,
  input  logic                             mem_rst_i,
  input  logic                             req_valid_i,
  output logic                             req_rdy_o,
  input  logic                             req_we_i,
  input  logic [DDR4_APP_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DDR4_APP_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DDR4_APP_DATA_WIDTH/8-1:0] req_be_i,
  input  logic [TAG_WIDTH-1:0]             req_tag_i,
  output logic                             resp_valid_o,
  input  logic                             resp_rdy_i,
  output logic [DDR4_APP_DATA_WIDTH-1:0]   resp_rdata_o,
  output logic [TAG_WIDTH-1:0]             resp_tag_o,
  output logic                             err_unexp_rd_o,
  output logic [DDR4_APP_ADDR_WIDTH-1:0]   bridge_app_addr_o,
  output logic [DDR4_APP_CMD_WIDTH-1:0]    bridge_app_cmd_o,
  output logic                             bridge_app_en_o,
  output logic [DDR4_APP_DATA_WIDTH-1:0]   bridge_app_wdf_data_o,
  output logic                             bridge_app_wdf_end_o,
  output logic [DDR4_APP_DATA_WIDTH/8-1:0] bridge_app_wdf_mask_o,
  output logic                             bridge_app_wdf_wren_o,
  input  logic                             bridge_app_rdy_i,
  input  logic                             bridge_app_wdf_rdy_i,
  input  logic [DDR4_APP_DATA_WIDTH-1:0]   bridge_app_rd_data_i,
  input  logic                             bridge_app_rd_data_end_i,
  input  logic                             bridge_app_rd_data_valid_i
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] MAX_C = (PW+1)'(MAX_OUTSTANDING);
  localparam logic [PW:0] ONE = (PW+1)'(1);
  localparam logic [DDR4_APP_CMD_WIDTH-1:0] CMD_WR = '0;
  localparam logic [DDR4_APP_CMD_WIDTH-1:0] CMD_RD = DDR4_APP_CMD_WIDTH'(1);
  typedef enum logic {EMPTY, HOLD} state_t;
  state_t state, state_nxt;
  logic [PW:0] credits, in_flight, wr_ptr, tag_wr_ptr, rd_ptr;
  logic [DDR4_APP_DATA_WIDTH-1:0] resp_mem [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  logic is_rd, issue, accept, rd_accept, ret, ret_ok, pop;
  assign is_rd = bridge_app_cmd_o == CMD_RD;
  assign bridge_app_en_o = state == HOLD;
  assign bridge_app_wdf_wren_o = bridge_app_en_o && !is_rd;
  assign bridge_app_wdf_end_o = bridge_app_en_o && !is_rd;
  assign issue = bridge_app_en_o && bridge_app_rdy_i && (is_rd || bridge_app_wdf_rdy_i);
  // Ready never looks at req_valid_i, only at the slot and the credit count.
  assign req_rdy_o = !mem_rst_i && (state == EMPTY || issue) && credits < MAX_C;
  assign accept = req_valid_i && req_rdy_o;
  assign rd_accept = accept && !req_we_i;
  assign ret = bridge_app_rd_data_valid_i && bridge_app_rd_data_end_i;
  assign ret_ok = ret && in_flight != '0;
  assign resp_valid_o = wr_ptr != rd_ptr;
  assign pop = resp_valid_o && resp_rdy_i;
  assign resp_rdata_o = resp_mem[rd_ptr[PW-1:0]];
  assign resp_tag_o = tag_mem[rd_ptr[PW-1:0]];
  always_comb state_nxt = accept ? HOLD : (issue ? EMPTY : state);
  always_ff @(posedge mem_clk_i) begin
    if (mem_rst_i) begin
      state <= EMPTY;
      bridge_app_cmd_o <= CMD_WR;
      bridge_app_addr_o <= '0;
      bridge_app_wdf_data_o <= '0;
      bridge_app_wdf_mask_o <= '1;
      credits <= '0;
      in_flight <= '0;
      wr_ptr <= '0;
      tag_wr_ptr <= '0;
      rd_ptr <= '0;
      err_unexp_rd_o <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bridge_app_cmd_o <= req_we_i ? CMD_WR : CMD_RD;
        bridge_app_addr_o <= req_addr_i;
        bridge_app_wdf_data_o <= req_wdata_i;
        bridge_app_wdf_mask_o <= ~req_be_i;
      end
      credits <= credits + (rd_accept ? ONE : '0) - (pop ? ONE : '0);
      in_flight <= in_flight + ((issue && is_rd) ? ONE : '0) - (ret_ok ? ONE : '0);
      if (ret && in_flight == '0) err_unexp_rd_o <= 1'b1;
      if (ret_ok) wr_ptr <= wr_ptr + ONE;
      if (rd_accept) tag_wr_ptr <= tag_wr_ptr + ONE;
      if (pop) rd_ptr <= rd_ptr + ONE;
    end
  end
  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge mem_clk_i) begin
    if (ret_ok) resp_mem[wr_ptr[PW-1:0]] <= bridge_app_rd_data_i;
    if (rd_accept) tag_mem[tag_wr_ptr[PW-1:0]] <= req_tag_i;
  end
endmodule
